// File: rtl/control_unit_pipelined_if.sv
// ID-stage instruction fields from the hazard/datapath side, and pipelined control
// returned by the control unit.
interface control_unit_pipelined_if #(
   parameter int unsigned ALU_CTRL_W = 3
);
   logic [6:0]            op_d;
   logic [2:0]            funct3_d;
   logic [6:0]            funct7_d;
   logic                  stall_d;
   logic                  flush_e;
   logic [1:0]            imm_src_d;
   logic                  branch_d;
   logic                  jump_d;
   logic [ALU_CTRL_W-1:0] alu_control_e;
   logic                  alu_src_e;
   logic                  branch_e;
   logic                  jump_e;
   logic [1:0]            fpu_op_e;
   logic                  fpu_en_e;
   logic                  fpu_start_e;
   logic                  fpu_stall;
   logic                  mem_write_m;
   logic                  reg_write_w;
   logic                  freg_write_w;
   logic [1:0]            result_src_w;
   logic                  illegal_e;

   modport master (
      output op_d, funct3_d, funct7_d, stall_d, flush_e,
      input  imm_src_d, branch_d, jump_d, alu_control_e, alu_src_e, branch_e, jump_e,
             fpu_op_e, fpu_en_e, fpu_start_e, fpu_stall, mem_write_m, reg_write_w,
             freg_write_w, result_src_w, illegal_e
   );

   modport slave (
      input  op_d, funct3_d, funct7_d, stall_d, flush_e,
      output imm_src_d, branch_d, jump_d, alu_control_e, alu_src_e, branch_e, jump_e,
             fpu_op_e, fpu_en_e, fpu_start_e, fpu_stall, mem_write_m, reg_write_w,
             freg_write_w, result_src_w, illegal_e
   );
endinterface

// File: rtl/control_unit_pipelined.sv
// RV32 control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control pipeline and
// the multi-cycle FPU sequencer that freezes the front end during fmul/fdiv.
module control_unit_pipelined #(
   parameter int unsigned ALU_CTRL_W = 3,
   parameter int unsigned FPU_LAT    = 4,
   parameter int unsigned LAT_W      = 3
) (
   input logic                    clk,
   input logic                    reset_n,
   control_unit_pipelined_if.slave bus
);
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;
   localparam logic [6:0] OPC_JAL = 7'b1101111;
   localparam logic [6:0] OPC_FP  = 7'b1010011;

   typedef struct packed {
      logic                  reg_write;
      logic                  freg_write;
      logic [1:0]            result_src;
      logic                  mem_write;
      logic                  branch;
      logic                  jump;
      logic                  alu_src;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic                  fpu_en;
      logic [1:0]            fpu_op;
      logic                  illegal;
   } ctrl_t;

   typedef struct packed {
      logic       reg_write;
      logic       freg_write;
      logic [1:0] result_src;
      logic       mem_write;
   } mem_ctrl_t;

   typedef struct packed {
      logic       reg_write;
      logic       freg_write;
      logic [1:0] result_src;
   } wb_ctrl_t;

   typedef enum logic {S_IDLE, S_BUSY} fpu_state_e;

   ctrl_t      dec;
   logic [1:0] imm_src;
   logic [1:0] alu_op;
   logic [2:0] alu_code;
   logic       alu_illegal;

   ctrl_t      idex_q, idex_d;
   mem_ctrl_t  exmem_q, exmem_d;
   wb_ctrl_t   memwb_q, memwb_d;

   fpu_state_e state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic       fpu_start;
   logic       fpu_stall;

   // Main decode
   always_comb begin
      dec     = '0;
      imm_src = 2'b00;
      alu_op  = 2'b00;
      case (bus.op_d)
         OPC_LW: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b01;
         end
         OPC_SW: begin
            imm_src       = 2'b01;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         OPC_R: begin
            dec.reg_write = 1'b1;
            alu_op        = 2'b10;
         end
         OPC_I: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            alu_op        = 2'b10;
         end
         OPC_BEQ: begin
            imm_src    = 2'b10;
            dec.branch = 1'b1;
            alu_op     = 2'b01;
         end
         OPC_JAL: begin
            dec.reg_write  = 1'b1;
            imm_src        = 2'b11;
            dec.jump       = 1'b1;
            dec.result_src = 2'b10;
         end
         OPC_FP: begin
            case (bus.funct7_d)
               7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100: begin
                  dec.freg_write = 1'b1;
                  dec.result_src = 2'b11;
                  dec.fpu_en     = 1'b1;
                  dec.fpu_op     = bus.funct7_d[3:2];
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         default: dec.illegal = 1'b1;
      endcase

      alu_code    = 3'b000;
      alu_illegal = 1'b0;
      case (alu_op)
         2'b00: alu_code = 3'b000;
         2'b01: alu_code = 3'b001;
         default: begin
            case (bus.funct3_d)
               3'b000: alu_code = (bus.op_d[5] & bus.funct7_d[5]) ? 3'b001 : 3'b000;
               3'b010: alu_code = 3'b101;
               3'b110: alu_code = 3'b011;
               3'b111: alu_code = 3'b010;
               default: begin
                  alu_code    = 3'b000;
                  alu_illegal = 1'b1;
               end
            endcase
         end
      endcase
      dec.alu_ctrl = ALU_CTRL_W'(alu_code);
      dec.illegal  = dec.illegal | alu_illegal;
   end

   // FPU sequencer: stall is raised in the start cycle of a long op so it never leaves EX early
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fpu_start = 1'b0;
      fpu_stall = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (idex_q.fpu_en) begin
               fpu_start = 1'b1;
               if (idex_q.fpu_op[1]) begin
                  fpu_stall = 1'b1;
                  state_d   = S_BUSY;
                  cnt_d     = LAT_W'(FPU_LAT - 1);
               end
            end
         end
         S_BUSY: begin
            if (cnt_q == LAT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               fpu_stall = 1'b1;
               cnt_d     = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      if (bus.flush_e) begin
         idex_d = '0;
      end else if (fpu_stall) begin
         idex_d = idex_q;
      end else if (bus.stall_d) begin
         idex_d = '0;
      end else begin
         idex_d = dec;
      end

      exmem_d = '0;
      if (!fpu_stall) begin
         exmem_d.reg_write  = idex_q.reg_write;
         exmem_d.freg_write = idex_q.freg_write;
         exmem_d.result_src = idex_q.result_src;
         exmem_d.mem_write  = idex_q.mem_write;
      end

      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.freg_write = exmem_q.freg_write;
      memwb_d.result_src = exmem_q.result_src;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   assign bus.imm_src_d     = imm_src;
   assign bus.branch_d      = dec.branch;
   assign bus.jump_d        = dec.jump;
   assign bus.alu_control_e = idex_q.alu_ctrl;
   assign bus.alu_src_e     = idex_q.alu_src;
   assign bus.branch_e      = idex_q.branch;
   assign bus.jump_e        = idex_q.jump;
   assign bus.fpu_op_e      = idex_q.fpu_op;
   assign bus.fpu_en_e      = idex_q.fpu_en;
   assign bus.illegal_e     = idex_q.illegal;
   assign bus.fpu_start_e   = fpu_start;
   assign bus.fpu_stall     = fpu_stall;
   assign bus.mem_write_m   = exmem_q.mem_write;
   assign bus.reg_write_w   = memwb_q.reg_write;
   assign bus.freg_write_w  = memwb_q.freg_write;
   assign bus.result_src_w  = memwb_q.result_src;
endmodule

// File: tb/tb_control_unit_pipelined.sv
// Bench for control_unit_pipelined: instruction-level pipeline model checked every
// cycle, plus directed literal expectations.
module tb_control_unit_pipelined;
   localparam int FPU_LAT = 4;

   localparam bit [6:0] OP_LW  = 7'b0000011;
   localparam bit [6:0] OP_SW  = 7'b0100011;
   localparam bit [6:0] OP_R   = 7'b0110011;
   localparam bit [6:0] OP_I   = 7'b0010011;
   localparam bit [6:0] OP_BR  = 7'b1100011;
   localparam bit [6:0] OP_JAL = 7'b1101111;
   localparam bit [6:0] OP_FP  = 7'b1010011;

   typedef struct packed {
      bit       rw, fw, mw, br, jp, as, en, il;
      bit [1:0] rs, imm, fop;
      bit [2:0] alu;
   } ctl_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   stall_cnt = 0, start_cnt = 0, freg_cnt = 0;

   ctl_t m_ex, m_mem, m_wb;
   int   m_age;

   always #5 clk = ~clk;

   control_unit_pipelined_if #(.ALU_CTRL_W(3)) bus ();

   control_unit_pipelined #(
      .ALU_CTRL_W(3),
      .FPU_LAT   (FPU_LAT),
      .LAT_W     (3)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Instruction semantics straight from the opcode/funct tables.
   function automatic ctl_t model_decode(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7);
      ctl_t c;
      c = '0;
      case (op)
         OP_LW:  begin c.rw = 1; c.as = 1; c.rs = 2'd1; end
         OP_SW:  begin c.imm = 2'd1; c.as = 1; c.mw = 1; end
         OP_R, OP_I: begin
            c.rw = 1;
            c.as = (op == OP_I);
            if (f3 == 3'd0)      c.alu = (op == OP_R && f7[5]) ? 3'd1 : 3'd0;
            else if (f3 == 3'd2) c.alu = 3'd5;
            else if (f3 == 3'd6) c.alu = 3'd3;
            else if (f3 == 3'd7) c.alu = 3'd2;
            else                 c.il  = 1;
         end
         OP_BR:  begin c.imm = 2'd2; c.br = 1; c.alu = 3'd1; end
         OP_JAL: begin c.rw = 1; c.imm = 2'd3; c.jp = 1; c.rs = 2'd2; end
         OP_FP: begin
            if (f7 == 7'd0 || f7 == 7'd4 || f7 == 7'd8 || f7 == 7'd12) begin
               c.fw = 1; c.rs = 2'd3; c.en = 1; c.fop = f7[3:2];
            end else begin
               c.il = 1;
            end
         end
         default: c.il = 1;
      endcase
      return c;
   endfunction

   // Per-cycle compare against the model, then advance the model across the coming edge.
   initial begin : compare
      ctl_t idc;
      bit   exp_stall, exp_start;
      m_ex = '0; m_mem = '0; m_wb = '0; m_age = 0;
      forever begin
         @(negedge clk);
         idc       = model_decode(bus.op_d, bus.funct3_d, bus.funct7_d);
         exp_stall = m_ex.en && m_ex.fop[1] && (m_age < FPU_LAT - 1);
         exp_start = m_ex.en && (m_age == 0);

         chk("imm_src_d",     bus.imm_src_d,     idc.imm);
         chk("branch_d",      bus.branch_d,      idc.br);
         chk("jump_d",        bus.jump_d,        idc.jp);
         chk("alu_control_e", bus.alu_control_e, m_ex.alu);
         chk("alu_src_e",     bus.alu_src_e,     m_ex.as);
         chk("branch_e",      bus.branch_e,      m_ex.br);
         chk("jump_e",        bus.jump_e,        m_ex.jp);
         chk("fpu_op_e",      bus.fpu_op_e,      m_ex.fop);
         chk("fpu_en_e",      bus.fpu_en_e,      m_ex.en);
         chk("illegal_e",     bus.illegal_e,     m_ex.il);
         chk("fpu_start_e",   bus.fpu_start_e,   exp_start);
         chk("fpu_stall",     bus.fpu_stall,     exp_stall);
         chk("mem_write_m",   bus.mem_write_m,   m_mem.mw);
         chk("reg_write_w",   bus.reg_write_w,   m_wb.rw);
         chk("freg_write_w",  bus.freg_write_w,  m_wb.fw);
         chk("result_src_w",  bus.result_src_w,  m_wb.rs);

         if (bus.fpu_stall === 1'b1)    stall_cnt++;
         if (bus.fpu_start_e === 1'b1)  start_cnt++;
         if (bus.freg_write_w === 1'b1) freg_cnt++;

         assert (!(bus.flush_e && bus.fpu_stall)) else $error("flush_e raised while fpu_stall");

         if (!reset_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_age = 0;
         end else begin
            m_wb  = m_mem;
            m_mem = exp_stall ? '0 : m_ex;
            if (bus.flush_e) begin
               m_ex = '0; m_age = 0;
            end else if (exp_stall) begin
               m_age++;
            end else if (bus.stall_d) begin
               m_ex = '0; m_age = 0;
            end else begin
               m_ex = idc; m_age = 0;
            end
         end
      end
   end

   task automatic apply(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                        input bit sd, input bit fe);
      bus.op_d     = op;
      bus.funct3_d = f3;
      bus.funct7_d = f7;
      bus.stall_d  = sd;
      bus.flush_e  = fe;
      @(posedge clk);
      #3;
   endtask

   task automatic ins(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7);
      apply(op, f3, f7, 1'b0, 1'b0);
   endtask

   initial begin : stimulus
      reset_n      = 1'b0;
      bus.op_d     = OP_R;
      bus.funct3_d = 3'd0;
      bus.funct7_d = 7'd0;
      bus.stall_d  = 1'b0;
      bus.flush_e  = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_alu_control_e", bus.alu_control_e, 0);
      chk("rst_reg_write_w",   bus.reg_write_w,   0);
      chk("rst_mem_write_m",   bus.mem_write_m,   0);
      chk("rst_fpu_stall",     bus.fpu_stall,     0);
      chk("rst_illegal_e",     bus.illegal_e,     0);

      reset_n = 1'b1;
      ins(OP_R, 3'd0, 7'd0);                       // add
      chk("add_alu", bus.alu_control_e, 0);
      ins(OP_R, 3'd0, 7'b0100000);                 // sub
      chk("sub_alu", bus.alu_control_e, 1);
      ins(OP_SW, 3'd2, 7'd0);                      // add now in WB
      chk("add_reg_write_w", bus.reg_write_w, 1);
      ins(OP_BR, 3'd0, 7'd0);
      chk("beq_branch_e", bus.branch_e, 1);
      chk("beq_alu", bus.alu_control_e, 1);
      chk("sw_mem_write_m", bus.mem_write_m, 1);
      ins(OP_JAL, 3'd0, 7'd0);
      chk("jal_jump_e", bus.jump_e, 1);
      ins(7'b1111111, 3'd0, 7'd0);
      chk("bad_op_illegal_e", bus.illegal_e, 1);
      ins(OP_I, 3'd0, 7'd0);                       // jal now in WB
      chk("jal_result_src_w", bus.result_src_w, 2);
      ins(OP_I, 3'd2, 7'd0);                       // bad opcode now in WB
      chk("slti_alu", bus.alu_control_e, 5);
      chk("bad_op_reg_write_w", bus.reg_write_w, 0);
      ins(OP_R, 3'd6, 7'd0);
      chk("or_alu", bus.alu_control_e, 3);
      ins(OP_R, 3'd7, 7'd0);
      chk("and_alu", bus.alu_control_e, 2);
      ins(OP_R, 3'd1, 7'd0);
      chk("sll_illegal_e", bus.illegal_e, 1);
      ins(OP_LW, 3'd2, 7'd0);
      chk("lw_alu_src_e", bus.alu_src_e, 1);
      ins(OP_FP, 3'd0, 7'b0010000);
      chk("badfp_illegal_e", bus.illegal_e, 1);
      chk("badfp_fpu_en_e", bus.fpu_en_e, 0);

      // fmul: one start pulse, three stall cycles, single FP writeback
      ins(OP_FP, 3'd0, 7'b0001000);
      stall_cnt = 0; start_cnt = 0; freg_cnt = 0;
      chk("fmul_start", bus.fpu_start_e, 1);
      chk("fmul_stall", bus.fpu_stall, 1);
      chk("fmul_op", bus.fpu_op_e, 2);
      repeat (7) ins(OP_I, 3'd0, 7'd0);
      chk("fmul_stall_cycles", stall_cnt, 3);
      chk("fmul_start_pulses", start_cnt, 1);
      chk("fmul_freg_writes", freg_cnt, 1);

      // fadd then fsub back to back
      ins(OP_FP, 3'd0, 7'd0);
      stall_cnt = 0; start_cnt = 0;
      chk("fadd_op", bus.fpu_op_e, 0);
      chk("fadd_start", bus.fpu_start_e, 1);
      ins(OP_FP, 3'd0, 7'b0000100);
      chk("fsub_op", bus.fpu_op_e, 1);
      chk("fsub_start", bus.fpu_start_e, 1);
      repeat (2) ins(OP_I, 3'd0, 7'd0);
      chk("faddsub_start_pulses", start_cnt, 2);
      chk("faddsub_stall_cycles", stall_cnt, 0);

      // stall_d bubble, then flush
      apply(OP_LW, 3'd2, 7'd0, 1'b1, 1'b0);
      chk("stall_bubble_alu_src", bus.alu_src_e, 0);
      apply(OP_LW, 3'd2, 7'd0, 1'b0, 1'b0);
      chk("lw_after_stall_alu_src", bus.alu_src_e, 1);
      apply(OP_BR, 3'd0, 7'd0, 1'b0, 1'b1);
      chk("flush_branch_e", bus.branch_e, 0);
      ins(OP_I, 3'd0, 7'd0);

      // fdiv interrupted by reset on its second BUSY cycle
      ins(OP_FP, 3'd0, 7'b0001100);
      freg_cnt = 0;
      chk("fdiv_op", bus.fpu_op_e, 3);
      ins(OP_I, 3'd0, 7'd0);
      ins(OP_I, 3'd0, 7'd0);
      chk("fdiv_busy_stall", bus.fpu_stall, 1);
      reset_n = 1'b0;
      ins(OP_I, 3'd0, 7'd0);
      chk("fdiv_rst_stall", bus.fpu_stall, 0);
      chk("fdiv_rst_fpu_en", bus.fpu_en_e, 0);
      reset_n = 1'b1;
      repeat (6) ins(OP_I, 3'd0, 7'd0);
      chk("fdiv_rst_no_freg_write", freg_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
